// File: rtl/spi_pkg.sv
// Shared types and command codes for the burst-capable SPI slave.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CHK_CMD   = 3'd1,
      ST_WRITE     = 3'd2,
      ST_READ_ADD  = 3'd3,
      ST_READ_DATA = 3'd4,
      ST_WAIT_TX   = 3'd5,
      ST_SEND      = 3'd6,
      ST_HOLD      = 3'd7
   } spi_state_e;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// Shift register with parallel load and a shift counter.
// It shifts in either direction; last_o flags that the next shift completes the word.
module spi_shift_reg #(
   parameter int W         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_data_i,
   input  logic         shift_i,
   input  logic         bit_i,
   output logic [W-1:0] shifted_o,
   output logic         last_o
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  data_q;
   logic [CW-1:0] cnt_q;

   // Next value on a shift; on the final shift this is the completed word.
   always_comb begin
      if (MSB_FIRST) begin
         shifted_o = {data_q[W-2:0], bit_i};
      end else begin
         shifted_o = {bit_i, data_q[W-1:1]};
      end
   end

   assign last_o = (cnt_q == CW'(W - 1));

   // Data and counter update; the counter wraps after the last shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else if (clr_i) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else if (load_i) begin
         data_q <= load_data_i;
         cnt_q  <= '0;
      end else if (shift_i) begin
         data_q <= shifted_o;
         cnt_q  <= last_o ? '0 : cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/spi_slave_burst.sv
// SPI slave sitting between the pins and the single-port RAM wrapper.
// It receives command frames, serialises read data, supports bursts, and reports timeouts and frame errors.
module spi_slave_burst
   import spi_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter bit MSB_FIRST   = 1'b1,
   parameter bit BURST_EN    = 1'b1,
   parameter int TX_WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   output logic              MISO,
   output logic              busy,
   output logic              frame_err,
   output logic              tx_timeout
);

   localparam int FW  = DATA_W + 2;
   localparam int WCW = $clog2(TX_WAIT_MAX + 1);

   spi_state_e        state_q;
   logic [FW-1:0]     rx_data_q;
   logic              rx_valid_q;
   logic              miso_q;
   logic              frame_err_q;
   logic              tx_timeout_q;
   logic              rd_pend_q;
   logic [WCW-1:0]    wait_q;

   logic              rx_clr_s;
   logic              rx_shift_s;
   logic              rx_last_s;
   logic [FW-1:0]     rx_shifted_s;
   logic              tx_load_s;
   logic              tx_shift_s;
   logic              tx_last_s;
   logic [DATA_W-1:0] tx_shifted_s;
   logic              tx_first_bit_s;
   logic              tx_next_bit_s;
   logic              tx_shift_unused_s;

   spi_shift_reg #(.W(FW), .MSB_FIRST(MSB_FIRST)) u_rx_sr (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (rx_clr_s),
      .load_i      (1'b0),
      .load_data_i ({FW{1'b0}}),
      .shift_i     (rx_shift_s),
      .bit_i       (MOSI),
      .shifted_o   (rx_shifted_s),
      .last_o      (rx_last_s)
   );

   spi_shift_reg #(.W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_tx_sr (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (1'b0),
      .load_i      (tx_load_s),
      .load_data_i (tx_data),
      .shift_i     (tx_shift_s),
      .bit_i       (1'b0),
      .shifted_o   (tx_shifted_s),
      .last_o      (tx_last_s)
   );

   // Shift-register strobes and the MISO bit selection for the active bit order.
   always_comb begin
      rx_clr_s   = (state_q == ST_IDLE);
      rx_shift_s = (state_q inside {ST_CHK_CMD, ST_WRITE, ST_READ_ADD, ST_READ_DATA});
      tx_load_s  = (state_q == ST_WAIT_TX) && tx_valid;
      tx_shift_s = (state_q == ST_SEND) && !tx_last_s;
      if (MSB_FIRST) begin
         tx_first_bit_s = tx_data[DATA_W-1];
         tx_next_bit_s  = tx_shifted_s[DATA_W-1];
      end else begin
         tx_first_bit_s = tx_data[0];
         tx_next_bit_s  = tx_shifted_s[0];
      end
   end

   assign tx_shift_unused_s = ^tx_shifted_s;

   // Control FSM; MISO is zero unless a data bit is being presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         miso_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         tx_timeout_q <= 1'b0;
         rd_pend_q    <= 1'b0;
         wait_q       <= '0;
      end else begin
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         tx_timeout_q <= 1'b0;
         miso_q       <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!SS_n) state_q <= ST_CHK_CMD;
            end
            // The first sampled bit selects the receive path.
            ST_CHK_CMD: begin
               if (SS_n) begin
                  state_q     <= ST_IDLE;
                  frame_err_q <= 1'b1;
               end else if (!MOSI) begin
                  state_q <= ST_WRITE;
               end else if (rd_pend_q) begin
                  state_q <= ST_READ_DATA;
               end else begin
                  state_q <= ST_READ_ADD;
               end
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
               if (rx_last_s) begin
                  rx_data_q  <= rx_shifted_s;
                  rx_valid_q <= 1'b1;
                  wait_q     <= '0;
                  if (state_q == ST_READ_ADD)  rd_pend_q <= 1'b1;
                  if (state_q == ST_READ_DATA) rd_pend_q <= 1'b0;
                  if (SS_n) begin
                     state_q <= ST_IDLE;
                  end else if (state_q == ST_READ_DATA) begin
                     state_q <= ST_WAIT_TX;
                  end else begin
                     state_q <= ST_HOLD;
                  end
               end else if (SS_n) begin
                  state_q     <= ST_IDLE;
                  frame_err_q <= 1'b1;
               end
            end
            ST_WAIT_TX: begin
               if (SS_n) begin
                  state_q <= ST_IDLE;
               end else if (tx_valid) begin
                  state_q <= ST_SEND;
                  miso_q  <= tx_first_bit_s;
               end else if (wait_q == WCW'(TX_WAIT_MAX - 1)) begin
                  state_q      <= ST_HOLD;
                  tx_timeout_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + WCW'(1);
               end
            end
            // Once the final bit has been shown, SS_n decides between burst and hold.
            ST_SEND: begin
               if (tx_last_s) begin
                  if (BURST_EN && !SS_n) begin
                     rx_data_q  <= {CMD_RD_DATA, {DATA_W{1'b0}}};
                     rx_valid_q <= 1'b1;
                     wait_q     <= '0;
                     state_q    <= ST_WAIT_TX;
                  end else begin
                     state_q <= ST_HOLD;
                  end
               end else if (SS_n) begin
                  state_q     <= ST_IDLE;
                  frame_err_q <= 1'b1;
               end else begin
                  miso_q <= tx_next_bit_s;
               end
            end
            ST_HOLD: begin
               if (SS_n) state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign MISO       = miso_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_err  = frame_err_q;
   assign tx_timeout = tx_timeout_q;

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench: an MSB-first burst instance plus an LSB-first instance for bit order and async reset.
module tb_spi_slave_burst;

   logic       clk;
   logic       rst_n, ss_n, mosi, tx_valid;
   logic [7:0] tx_data;
   logic [9:0] rx_data;
   logic       rx_valid, miso, busy, frame_err, tx_timeout;

   logic       rst_l_n, ss_l_n, mosi_l, tx_valid_l;
   logic [7:0] tx_data_l;
   logic [9:0] rx_data_l;
   logic       rx_valid_l, miso_l, busy_l, frame_err_l, tx_timeout_l;

   int checks;
   int failures;

   spi_slave_burst #(.DATA_W(8), .MSB_FIRST(1'b1), .BURST_EN(1'b1), .TX_WAIT_MAX(15)) u_dut (
      .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .tx_valid(tx_valid), .tx_data(tx_data),
      .rx_data(rx_data), .rx_valid(rx_valid), .MISO(miso), .busy(busy),
      .frame_err(frame_err), .tx_timeout(tx_timeout)
   );

   spi_slave_burst #(.DATA_W(8), .MSB_FIRST(1'b0), .BURST_EN(1'b1), .TX_WAIT_MAX(15)) u_lsb (
      .clk(clk), .rst_n(rst_l_n), .SS_n(ss_l_n), .MOSI(mosi_l), .tx_valid(tx_valid_l), .tx_data(tx_data_l),
      .rx_data(rx_data_l), .rx_valid(rx_valid_l), .MISO(miso_l), .busy(busy_l),
      .frame_err(frame_err_l), .tx_timeout(tx_timeout_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // MSB-first frame on the main instance; optional tx_valid pulse on the last bit.
   task automatic frame_m(input logic [9:0] f, input logic pulse_last);
      for (int i = 9; i >= 0; i--) begin
         mosi     = f[i];
         tx_valid = (i == 0) ? pulse_last : 1'b0;
         tick();
         chk("miso_rx", miso, 1'b0);
         if (i > 0) chk("rx_valid_mid", rx_valid, 1'b0);
      end
      tx_valid = 1'b0;
   endtask

   task automatic frame_l(input logic [9:0] f);
      for (int i = 0; i <= 9; i++) begin
         mosi_l = f[i];
         tick();
      end
   endtask

   // Checks eight MISO bits, MSB first, one per cycle after capture.
   task automatic word_m(input logic [7:0] w);
      for (int k = 7; k >= 0; k--) begin
         chk("miso_bit", miso, w[k]);
         tick();
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      rst_l_n = 1'b0; ss_l_n = 1'b1; mosi_l = 1'b0; tx_valid_l = 1'b0; tx_data_l = 8'h00;
      tick();
      tick();
      chk("rst_rx_data", rx_data, 10'h000);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_miso", miso, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_tx_timeout", tx_timeout, 1'b0);
      rst_n = 1'b1;
      rst_l_n = 1'b1;
      tick();

      // Write-address frame
      ss_n = 1'b0;
      tick();
      chk("busy_chk_cmd", busy, 1'b1);
      frame_m(10'h0A5, 1'b0);
      chk("wa_rx_valid", rx_valid, 1'b1);
      chk("wa_rx_data", rx_data, 10'h0A5);
      tick();
      chk("wa_rx_valid_one", rx_valid, 1'b0);
      chk("wa_hold_busy", busy, 1'b1);
      ss_n = 1'b1;
      tick();
      chk("wa_idle_busy", busy, 1'b0);

      // Read-address, then read-data with tx_valid three cycles after entry
      ss_n = 1'b0;
      tick();
      frame_m(10'h20F, 1'b0);
      chk("ra_rx_data", rx_data, 10'h20F);
      tick();
      ss_n = 1'b1;
      tick();
      ss_n = 1'b0;
      tick();
      frame_m(10'h3FF, 1'b0);
      chk("rd_rx_valid", rx_valid, 1'b1);
      chk("rd_rx_data", rx_data, 10'h3FF);
      tick();
      tick();
      chk("rd_wait_miso", miso, 1'b0);
      tx_valid = 1'b1;
      tx_data  = 8'hC3;
      tick();
      tx_valid = 1'b0;
      word_m(8'hC3);
      chk("rd_end_miso", miso, 1'b0);
      chk("rd_burst_valid", rx_valid, 1'b1);
      chk("rd_burst_data", rx_data, 10'h300);
      ss_n = 1'b1;
      tick();
      chk("wait_exit_err", frame_err, 1'b0);
      chk("wait_exit_busy", busy, 1'b0);

      // Burst of two words with SS_n held low
      ss_n = 1'b0;
      tick();
      frame_m(10'h2F0, 1'b0);
      tick();
      ss_n = 1'b1;
      tick();
      ss_n = 1'b0;
      tick();
      frame_m(10'h3FF, 1'b0);
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      tick();
      tx_valid = 1'b0;
      word_m(8'h5A);
      chk("b1_rx_valid", rx_valid, 1'b1);
      chk("b1_rx_data", rx_data, 10'h300);
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      tick();
      tx_valid = 1'b0;
      word_m(8'h3C);
      chk("b2_rx_valid", rx_valid, 1'b1);
      chk("b2_miso_end", miso, 1'b0);
      ss_n = 1'b1;
      tick();
      chk("b_idle_busy", busy, 1'b0);

      // Abort after five bits of a write-data frame
      ss_n = 1'b0;
      tick();
      for (int i = 9; i >= 5; i--) begin
         mosi = 1'b1 ^ (i == 9);
         tick();
      end
      ss_n = 1'b1;
      tick();
      chk("ab_frame_err", frame_err, 1'b1);
      chk("ab_rx_valid", rx_valid, 1'b0);
      chk("ab_busy", busy, 1'b0);
      chk("ab_rx_data_hold", rx_data, 10'h300);
      tick();
      chk("ab_err_one", frame_err, 1'b0);
      ss_n = 1'b0;
      tick();
      frame_m(10'h1F0, 1'b0);
      chk("wd_rx_valid", rx_valid, 1'b1);
      chk("wd_rx_data", rx_data, 10'h1F0);
      tick();
      ss_n = 1'b1;
      tick();

      // Timeout: tx_valid only on the last frame bit, before WAIT_TX entry
      ss_n = 1'b0;
      tick();
      frame_m(10'h20F, 1'b0);
      tick();
      ss_n = 1'b1;
      tick();
      ss_n = 1'b0;
      tick();
      tx_data = 8'hFF;
      frame_m(10'h3FF, 1'b1);
      for (int c = 1; c <= 14; c++) begin
         tick();
         chk("to_early", tx_timeout, 1'b0);
      end
      tick();
      chk("to_pulse", tx_timeout, 1'b1);
      chk("to_miso", miso, 1'b0);
      tick();
      chk("to_pulse_one", tx_timeout, 1'b0);
      chk("to_hold_busy", busy, 1'b1);
      ss_n = 1'b1;
      tick();
      chk("to_idle_busy", busy, 1'b0);

      // LSB-first instance: receive order, send order, async reset mid-send
      ss_l_n = 1'b0;
      tick();
      frame_l(10'h2A5);
      chk("l_rx_valid", rx_valid_l, 1'b1);
      chk("l_rx_data", rx_data_l, 10'h2A5);
      tick();
      ss_l_n = 1'b1;
      tick();
      ss_l_n = 1'b0;
      tick();
      frame_l(10'h3FF);
      chk("l_rd_rx_data", rx_data_l, 10'h3FF);
      tx_valid_l = 1'b1;
      tx_data_l  = 8'h07;
      tick();
      tx_valid_l = 1'b0;
      chk("l_miso_b0", miso_l, 1'b1);
      tick();
      chk("l_miso_b1", miso_l, 1'b1);
      tick();
      chk("l_miso_b2", miso_l, 1'b1);
      chk("l_busy_send", busy_l, 1'b1);
      #2;
      rst_l_n = 1'b0;
      #1;
      chk("l_rst_miso", miso_l, 1'b0);
      chk("l_rst_busy", busy_l, 1'b0);
      chk("l_rst_rx_data", rx_data_l, 10'h000);
      chk("l_rst_rx_valid", rx_valid_l, 1'b0);
      chk("l_rst_frame_err", frame_err_l, 1'b0);
      chk("l_rst_tx_timeout", tx_timeout_l, 1'b0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
